// File: rtl/pulse_sequencer.sv
// Discharge pulse-train sequencer: Ton, dead gap, Toff with de-ionisation window.
// Owns start/stop control and the safe-point hand-over of new Ton/Toff pairs.
module pulse_sequencer #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned DEAD_CYC  = 3,
   parameter int unsigned DEION_CYC = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_req,
   input  logic             stop_req,
   input  logic             param_valid,
   output logic             param_ready,
   input  logic [CNT_W-1:0] ton_in,
   input  logic [CNT_W-1:0] toff_in,
   output logic             pulse_on,
   output logic             deion_on,
   output logic             is_operation,
   output logic             cycle_done,
   output logic             param_applied,
   output logic [1:0]       state_o
);

   localparam int unsigned DW = $clog2(DEION_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TON  = 2'd1,
      S_DEAD = 2'd2,
      S_TOFF = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [DW-1:0]    dleft, dleft_nxt;
   logic [CNT_W-1:0] ton_act, ton_act_nxt, toff_act, toff_act_nxt;
   logic [CNT_W-1:0] ton_stg, ton_stg_nxt, toff_stg, toff_stg_nxt;
   logic [CNT_W-1:0] ton_eff;
   logic             pending, pending_nxt;
   logic             stop_flag, stop_nxt;
   logic             accept, toff_end, apply;
   logic             pulse_on_nxt, deion_on_nxt, cycle_done_nxt, param_applied_nxt;

   // State, counters and parameter registers; outputs are flopped from next-state values
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         dleft         <= '0;
         ton_act       <= CNT_W'(1);
         toff_act      <= CNT_W'(1);
         ton_stg       <= CNT_W'(1);
         toff_stg      <= CNT_W'(1);
         pending       <= 1'b0;
         stop_flag     <= 1'b0;
         param_ready   <= 1'b1;
         pulse_on      <= 1'b0;
         deion_on      <= 1'b0;
         is_operation  <= 1'b0;
         cycle_done    <= 1'b0;
         param_applied <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         dleft         <= dleft_nxt;
         ton_act       <= ton_act_nxt;
         toff_act      <= toff_act_nxt;
         ton_stg       <= ton_stg_nxt;
         toff_stg      <= toff_stg_nxt;
         pending       <= pending_nxt;
         stop_flag     <= stop_nxt;
         param_ready   <= ~pending_nxt;
         pulse_on      <= pulse_on_nxt;
         deion_on      <= deion_on_nxt;
         is_operation  <= (state_nxt != S_IDLE);
         cycle_done    <= cycle_done_nxt;
         param_applied <= param_applied_nxt;
      end
   end

   assign state_o = state;

   // Next-state, counter and parameter hand-over logic
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      dleft_nxt    = dleft;
      ton_act_nxt  = ton_act;
      toff_act_nxt = toff_act;
      ton_stg_nxt  = ton_stg;
      toff_stg_nxt = toff_stg;
      pending_nxt  = pending;
      stop_nxt     = stop_flag;

      accept   = param_valid & ~pending;
      toff_end = (state == S_TOFF) && (cnt == '0);
      // Pending pair goes live only while idle or at a Toff end, always as a pair
      apply    = pending && ((state == S_IDLE) || toff_end);
      ton_eff  = apply ? ton_stg : ton_act;

      if (apply) begin
         ton_act_nxt  = ton_stg;
         toff_act_nxt = toff_stg;
         pending_nxt  = 1'b0;
      end

      case (state)
         S_IDLE: begin
            if (start_req && !stop_req) begin
               state_nxt = S_TON;
               cnt_nxt   = ton_eff - CNT_W'(1);
            end
         end
         S_TON: begin
            if (stop_req || (cnt == '0)) begin
               state_nxt = S_DEAD;
               cnt_nxt   = CNT_W'(DEAD_CYC - 1);
               stop_nxt  = stop_flag | stop_req;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_DEAD: begin
            stop_nxt = stop_flag | stop_req;
            if (cnt == '0) begin
               state_nxt = S_TOFF;
               cnt_nxt   = toff_act - CNT_W'(1);
               dleft_nxt = DW'(DEION_CYC - 1);
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_TOFF: begin
            if (dleft != '0) dleft_nxt = dleft - DW'(1);
            if (cnt == '0) begin
               if (stop_flag || stop_req) begin
                  state_nxt = S_IDLE;
                  stop_nxt  = 1'b0;
               end else begin
                  state_nxt = S_TON;
                  cnt_nxt   = ton_eff - CNT_W'(1);
               end
            end else begin
               cnt_nxt  = cnt - CNT_W'(1);
               stop_nxt = stop_flag | stop_req;
            end
         end
         default: ;
      endcase

      // A pair staged on the Toff-end cycle waits for the following Toff end
      if (accept) begin
         ton_stg_nxt  = (ton_in == '0) ? CNT_W'(1) : ton_in;
         toff_stg_nxt = (toff_in == '0) ? CNT_W'(1) : toff_in;
         pending_nxt  = 1'b1;
      end

      pulse_on_nxt      = (state_nxt == S_TON);
      deion_on_nxt      = (state_nxt == S_TOFF) && ((state != S_TOFF) || (dleft != '0));
      cycle_done_nxt    = (state_nxt == S_TOFF) && (cnt_nxt == '0);
      param_applied_nxt = pending_nxt && ((state_nxt == S_IDLE) || cycle_done_nxt);
   end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer: a period-position reference model queues
// expected outputs per cycle; a monitor compares them against the DUT.
module tb_pulse_sequencer;

   localparam int unsigned CNT_W     = 16;
   localparam int          DEAD_CYC  = 3;
   localparam int          DEION_CYC = 20;

   logic             clk = 1'b0;
   logic             rst, start_req, stop_req, param_valid;
   logic [CNT_W-1:0] ton_in, toff_in;
   logic             param_ready, pulse_on, deion_on, is_operation, cycle_done, param_applied;
   logic [1:0]       state_o;

   always #5 clk = ~clk;

   pulse_sequencer #(.CNT_W(CNT_W), .DEAD_CYC(DEAD_CYC), .DEION_CYC(DEION_CYC)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_req     (start_req),
      .stop_req      (stop_req),
      .param_valid   (param_valid),
      .param_ready   (param_ready),
      .ton_in        (ton_in),
      .toff_in       (toff_in),
      .pulse_on      (pulse_on),
      .deion_on      (deion_on),
      .is_operation  (is_operation),
      .cycle_done    (cycle_done),
      .param_applied (param_applied),
      .state_o       (state_o)
   );

   // Reference model: position within the current period decides every output
   bit   m_run, m_pend, m_stop;
   int   m_t, m_ton, m_toff, m_ton_s, m_toff_s;
   logic [7:0] exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [7:0] model_out();
      int  len;
      int  toff_pos;
      bit  last;
      logic [1:0] st;
      len      = m_ton + DEAD_CYC + m_toff;
      toff_pos = m_t - m_ton - DEAD_CYC;
      last     = m_run && (m_t == len - 1);
      if (!m_run)                          st = 2'd0;
      else if (m_t < m_ton)                st = 2'd1;
      else if (m_t < m_ton + DEAD_CYC)     st = 2'd2;
      else                                 st = 2'd3;
      return {!m_pend,
              m_run && (m_t < m_ton),
              m_run && (toff_pos >= 0) && (toff_pos < DEION_CYC),
              m_run,
              last,
              m_pend && (!m_run || last),
              st};
   endfunction

   task automatic model_reset();
      m_run = 0; m_pend = 0; m_stop = 0; m_t = 0;
      m_ton = 1; m_toff = 1; m_ton_s = 1; m_toff_s = 1;
   endtask

   task automatic model_step(input bit s, input bit p, input bit v, input int ton, input int toff);
      bit acc;
      int len;
      acc = v && !m_pend;
      len = m_ton + DEAD_CYC + m_toff;
      if (!m_run) begin
         if (m_pend) begin m_ton = m_ton_s; m_toff = m_toff_s; m_pend = 0; end
         if (s && !p) begin m_run = 1; m_t = 0; end
      end else if ((m_t < m_ton) && p) begin
         m_stop = 1;
         m_t    = m_ton;
      end else if (m_t != len - 1) begin
         if (p) m_stop = 1;
         m_t++;
      end else begin
         if (m_pend) begin m_ton = m_ton_s; m_toff = m_toff_s; m_pend = 0; end
         if (m_stop || p) begin m_run = 0; m_stop = 0; end
         else m_t = 0;
      end
      if (acc) begin
         m_ton_s  = (ton == 0) ? 1 : ton;
         m_toff_s = (toff == 0) ? 1 : toff;
         m_pend   = 1;
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the next edge
   task automatic cyc(input bit r, input bit s, input bit p, input bit v, input int ton, input int toff);
      @(negedge clk);
      rst = r; start_req = s; stop_req = p; param_valid = v;
      ton_in = CNT_W'(ton); toff_in = CNT_W'(toff);
      if (r) model_reset();
      else   model_step(s, p, v, ton, toff);
      exp_q.push_back(model_out());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: compare the DUT outputs of every cycle against the queued expectation
   always @(posedge clk) begin
      logic [7:0] e, got;
      #1;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {param_ready, pulse_on, deion_on, is_operation, cycle_done, param_applied, state_o};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL outputs t=%0t got rdy/on/deion/op/done/appl/st=%b required %b", $time, got, e);
         end
         checks++;
         if (pulse_on && deion_on) begin
            errors++;
            $display("FAIL overlap t=%0t pulse_on=%b deion_on=%b required not both 1", $time, pulse_on, deion_on);
         end
      end
   end

   initial begin
      rst = 1; start_req = 0; stop_req = 0; param_valid = 0; ton_in = '0; toff_in = '0;
      model_reset();
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      // 5/10 staged in idle, then run a few periods
      cyc(0, 0, 0, 1, 5, 10);
      idle(2);
      cyc(0, 1, 0, 0, 0, 0);
      idle(40);
      // change to 5/30, then offer 8/40 during TON
      cyc(0, 0, 0, 1, 5, 30);
      idle(60);
      while (!(m_run && m_t == 1)) cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 8, 40);
      idle(120);
      // stop on the second TON cycle
      while (!(m_run && m_t == 1)) cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      idle(70);
      // stop mid-TOFF then restart one cycle after IDLE
      cyc(0, 1, 0, 0, 0, 0);
      while (!(m_run && m_t == 8 + DEAD_CYC + 10)) cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      while (m_run) cyc(0, 0, 0, 0, 0, 0);
      idle(1);
      cyc(0, 1, 0, 0, 0, 0);
      idle(30);
      // zero values clamp to 1/1
      cyc(0, 0, 0, 1, 0, 0);
      idle(80);
      cyc(0, 0, 1, 0, 0, 0);
      idle(10);
      cyc(0, 1, 1, 0, 0, 0);
      idle(4);
      // reset in the middle of TON
      cyc(0, 0, 0, 1, 6, 4);
      idle(2);
      cyc(0, 1, 0, 0, 0, 0);
      idle(2);
      cyc(1, 0, 0, 0, 0, 0);
      idle(4);
      // randomized traffic
      for (int i = 0; i < 4000; i++)
         cyc($urandom_range(0, 999) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0,
             $urandom_range(0, 9) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 30)));
      idle(2);
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain queue=%0d required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
- Sequences one discharge pulse train: Ton, then a dead-time gap, then Toff with a de-ionisation window.
- Owns the start/stop decision and the safe-point application of new Ton/Toff values.
- Sits between the command/key decode logic and the MOSFET drive mapping in the discharge control path, in the 100 MHz domain.
- All inputs are already synchronous to clk.

Parameters:
- CNT_W, 16, width of Ton/Toff values and counters (units: clk cycles).
- DEAD_CYC, 3, all-off gap between Ton end and Toff start (>=1).
- DEION_CYC, 20, de-ionisation cycles at the start of Toff (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- start_req  input  1  single-cycle start pulse.
- stop_req  input  1  single-cycle stop pulse.
- param_valid  input  1  new Ton/Toff pair offered.
- param_ready  output  1  pair accepted when valid&ready.
- ton_in  input  CNT_W  requested Ton.
- toff_in  input  CNT_W  requested Toff.
- pulse_on  output  1  discharge switch enable.
- deion_on  output  1  de-ionisation switch enable.
- is_operation  output  1  high while not IDLE.
- cycle_done  output  1  one-cycle pulse at each Toff end.
- param_applied  output  1  one-cycle pulse when staged values become active.
- state_o  output  2  IDLE=0, TON=1, DEAD=2, TOFF=3.

Behaviour:
- Reset: all outputs 0 except param_ready=1. State IDLE. Staged and active Ton/Toff = 1. Pending and stop flags cleared. rst mid-pulse drops pulse_on/deion_on on the next edge.
- Outputs are registered. pulse_on and deion_on are never high in the same cycle.
- Clamp: a value of 0 on ton_in/toff_in is stored as 1.
- Parameter handshake:
  - Accept when param_valid&param_ready; store into the staged registers and set pending.
  - param_ready = ~pending.
  - In IDLE, staged values are copied to active on the cycle after acceptance, with param_applied=1 and pending cleared.
  - While running, staged values are copied to active only at Toff end (safe point), with param_applied=1 and pending cleared. A Ton/Toff pair is never mixed.
- IDLE:
  - start_req -> TON; pulse_on high on the next cycle.
  - The down-counter is loaded with active Ton-1.
- TON:
  - pulse_on=1 for exactly active Ton cycles, then DEAD.
  - stop_req in TON truncates immediately: next cycle pulse_on=0, state DEAD, stop flag set.
- DEAD: all switches off for DEAD_CYC cycles, then TOFF with the counter loaded to active Toff-1.
- TOFF:
  - Lasts active Toff cycles.
  - deion_on=1 for the first min(DEION_CYC, Toff) cycles, then 0.
  - On the last cycle: cycle_done=1.
  - If the stop flag is set -> IDLE and clear the flag.
  - Otherwise apply pending params if any, then go to TON using the (possibly new) active Ton.
- stop_req in DEAD/TOFF sets the stop flag. The current Toff (including deion) always completes before IDLE.
- Simultaneous events:
  - start_req&stop_req in the same cycle: stop wins.
  - start_req outside IDLE is ignored.
  - stop_req in IDLE is ignored.
  - Param accept in the same cycle as Toff end: the new pair is staged but not applied until the next Toff end.
- Pulse period = Ton + DEAD_CYC + Toff cycles.
- The counter never wraps: maximum count is 2^CNT_W-1.

Test Plan:
- Reset, then param ton_in=5 toff_in=10 in IDLE, then start_req -> param_applied 1 cycle after accept. pulse_on high 5 cycles, 3 dead cycles, deion_on 10 cycles (DEION_CYC=20 clipped), cycle_done, repeat. Period 18.
- Running with Ton=5/Toff=30, offer ton_in=8 toff_in=40 during TON -> param_ready low until the current Toff end. Next Ton is 8, next Toff is 40, deion is 20 cycles. param_applied coincides with cycle_done.
- stop_req at 2nd cycle of TON -> pulse_on low next cycle, 3 dead cycles, full Toff with deion, then IDLE and is_operation=0.
- stop_req mid-TOFF -> Toff completes, no further pulse_on, IDLE. A start_req 1 cycle later restarts with active values.
- ton_in=0 toff_in=0 -> treated as 1/1. pulse_on 1 cycle, deion_on 1 cycle, period 5. start_req+stop_req in the same cycle from IDLE -> stays IDLE.
- Assert rst during TON -> next cycle all outputs 0, state_o=0, active values back to 1, param_ready=1.
